fetch_stage_ctrl: RTL and testbench

- Owns the program counter and drives the asynchronous instruction-ROM address.
- Captures the returned word, the PC and PC+4 into the IF/ID pipeline register for decode.
- Handles decode stalls, pipeline flushes and branch/jump redirects from execute.
- Flags fetches outside the ROM window or misaligned, and substitutes a NOP for them.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/pc_reg.sv | 45 ++++
 rtl/fetch_stage_ctrl.sv | 76 +++++++
 tb/tb_fetch_stage_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the IF/ID struct is also consumed by decode.
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam int          ROM_BYTES_DEFAULT    = 4096;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // A bubble keeps the pc fields of the entry it replaces.
    function automatic if_id_t if_id_bubble(input if_id_t cur);
        if_id_t b;
        b       = cur;
        b.valid = 1'b0;
        b.fault = 1'b0;
        b.instr = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and ROM-window legality check.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = RESET_VECTOR_DEFAULT,
    parameter int                         ROM_BYTES     = ROM_BYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic                     legal_o
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_FIRST = RESET_VECTOR;
    localparam logic [ADDRESS_WIDTH-1:0] PC_LAST  = RESET_VECTOR + ADDRESS_WIDTH'(ROM_BYTES - 4);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_target_i[ADDRESS_WIDTH-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_q + ADDRESS_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Unsigned compare against the last word so PC wrap past 2^32 reads as illegal.
    assign legal_o = (pc_q[1:0] == 2'b00) && (pc_q >= PC_FIRST) && (pc_q <= PC_LAST);
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: drives the ROM address from the PC and fills the IF/ID register.
module fetch_stage_ctrl
    import fetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH     = 32,
    parameter int                         INSTRUCTION_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR      = RESET_VECTOR_DEFAULT,
    parameter int                         ROM_BYTES         = ROM_BYTES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rd_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         redirect_i,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_target_i,
    output logic                         if_id_valid_o,
    output logic [ADDRESS_WIDTH-1:0]     if_id_pc_o,
    output logic [ADDRESS_WIDTH-1:0]     if_id_pc_plus4_o,
    output logic [INSTRUCTION_WIDTH-1:0] if_id_instr_o,
    output logic                         if_id_fault_o
);

    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     pc_legal;
    if_id_t                   if_id_q;
    if_id_t                   if_id_d;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_VECTOR  (RESET_VECTOR),
        .ROM_BYTES     (ROM_BYTES)
    ) u_pc_reg (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .pc_o              (pc),
        .legal_o           (pc_legal)
    );

    always_comb begin
        if_id_d = if_id_q;
        if (redirect_i || flush_i) begin
            if_id_d = if_id_bubble(if_id_q);
        end else if (!stall_i) begin
            if_id_d.valid    = 1'b1;
            if_id_d.fault    = !pc_legal;
            if_id_d.pc       = pc;
            if_id_d.pc_plus4 = pc + ADDRESS_WIDTH'(4);
            if_id_d.instr    = pc_legal ? imem_rd_i : NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q.valid    <= 1'b0;
            if_id_q.fault    <= 1'b0;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.instr    <= NOP_INSTR;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr_o      = pc;
    assign if_id_valid_o    = if_id_q.valid;
    assign if_id_fault_o    = if_id_q.fault;
    assign if_id_pc_o       = if_id_q.pc;
    assign if_id_pc_plus4_o = if_id_q.pc_plus4;
    assign if_id_instr_o    = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          ROM = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, redir;
    logic [31:0] tgt;
    logic [31:0] imem_addr, imem_rd;
    logic        v_o, f_o;
    logic [31:0] pc_o, pc4_o, instr_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    function automatic logic in_window(input logic [31:0] a);
        return (a % 4 == 0) && (a >= RV) && ((a - RV) < ROM);
    endfunction

    // ROM content: word index into the window plus 10; outside the window returns junk.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (in_window(a)) return ((a - RV) >> 2) + 32'd10;
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_rd = rom(imem_addr);

    fetch_stage_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .imem_addr_o       (imem_addr),
        .imem_rd_i         (imem_rd),
        .stall_i           (stall),
        .flush_i           (flush),
        .redirect_i        (redir),
        .redirect_target_i (tgt),
        .if_id_valid_o     (v_o),
        .if_id_pc_o        (pc_o),
        .if_id_pc_plus4_o  (pc4_o),
        .if_id_instr_o     (instr_o),
        .if_id_fault_o     (f_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the IF/ID entry and PC must be after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= RV; m_valid <= 0; m_fault <= 0;
            m_ipc <= 0; m_ipc4 <= 0; m_instr <= NOP;
        end else if (redir) begin
            m_pc <= tgt & ~32'd3;
            m_valid <= 0; m_fault <= 0; m_instr <= NOP;
        end else if (stall) begin
            if (flush) begin
                m_valid <= 0; m_fault <= 0; m_instr <= NOP;
            end
        end else begin
            m_pc <= m_pc + 4;
            if (flush) begin
                m_valid <= 0; m_fault <= 0; m_instr <= NOP;
            end else begin
                m_valid <= 1;
                m_ipc   <= m_pc;
                m_ipc4  <= m_pc + 4;
                m_fault <= !in_window(m_pc);
                m_instr <= in_window(m_pc) ? rom(m_pc) : NOP;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("addr",  imem_addr, m_pc);
            chk("valid", {31'd0, v_o}, {31'd0, m_valid});
            chk("fault", {31'd0, f_o}, {31'd0, m_fault});
            chk("pc",    pc_o, m_ipc);
            chk("pc4",   pc4_o, m_ipc4);
            chk("instr", instr_o, m_instr);
        end
    end

    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redir = r; tgt = t;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 0; flush = 0; redir = 0; tgt = 0;
        #1;
        chk("rst_addr",  imem_addr, RV);
        chk("rst_valid", {31'd0, v_o}, 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc",    pc_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rel_valid", {31'd0, v_o}, 32'd0);
        chk("rel_addr",  imem_addr, RV);

        step(0, 0, 0, 0);
        chk("first_pc",    pc_o, RV);
        chk("first_instr", instr_o, 32'hA);
        chk("first_valid", {31'd0, v_o}, 32'd1);
        chk("first_addr",  imem_addr, RV + 4);
        step(0, 0, 0, 0);
        chk("second_instr", instr_o, 32'hB);
        step(0, 0, 0, 0);
        chk("third_instr", instr_o, 32'hC);

        repeat (3) step(1, 0, 0, 0);
        chk("stall_addr",  imem_addr, RV + 12);
        chk("stall_instr", instr_o, 32'hC);
        step(0, 0, 0, 0);
        chk("resume_pc", pc_o, RV + 12);

        step(1, 0, 1, 32'hBFC0_0102);
        chk("redir_addr",  imem_addr, 32'hBFC0_0100);
        chk("redir_valid", {31'd0, v_o}, 32'd0);
        chk("redir_instr", instr_o, NOP);
        step(0, 0, 0, 0);
        chk("redir_cap_pc",    pc_o, 32'hBFC0_0100);
        chk("redir_cap_instr", instr_o, 32'h4A);
        chk("redir_cap_valid", {31'd0, v_o}, 32'd1);

        step(0, 0, 1, 32'hBFC0_0FF8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("last_pc",    pc_o, 32'hBFC0_0FFC);
        chk("last_fault", {31'd0, f_o}, 32'd0);
        chk("last_instr", instr_o, 32'h409);
        step(0, 0, 0, 0);
        chk("over_pc",    pc_o, 32'hBFC0_1000);
        chk("over_fault", {31'd0, f_o}, 32'd1);
        chk("over_instr", instr_o, NOP);
        chk("over_valid", {31'd0, v_o}, 32'd1);

        step(1, 1, 0, 0);
        chk("sf_valid", {31'd0, v_o}, 32'd0);
        chk("sf_addr",  imem_addr, 32'hBFC0_1004);
        step(0, 0, 0, 0);
        chk("sf_resume_pc", pc_o, 32'hBFC0_1004);

        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        chk("wrap_addr",  imem_addr, 32'd0);
        chk("wrap_fault", {31'd0, f_o}, 32'd1);
        step(0, 0, 0, 0);
        chk("zero_pc",    pc_o, 32'd0);
        chk("zero_fault", {31'd0, f_o}, 32'd1);

        step(0, 0, 1, RV);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? $urandom : RV + $urandom_range(0, ROM + 64);
            step($urandom_range(0, 99) < 20, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 24) == 0, t);
        end

        redir = 1'b1; tgt = 32'hBFC0_0800; stall = 0; flush = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_addr",  imem_addr, RV);
        chk("mid_rst_valid", {31'd0, v_o}, 32'd0);
        chk("mid_rst_instr", instr_o, NOP);
        chk("mid_rst_pc4",   pc4_o, 32'd0);
        chk("mid_rst_fault", {31'd0, f_o}, 32'd0);
        @(posedge clk);
        @(negedge clk); #1;
        redir = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, RV);
        step(0, 0, 0, 0);
        chk("post_rst_pc",    pc_o, RV);
        chk("post_rst_instr", instr_o, 32'hA);
        repeat (4) step(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
